// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/rotate engine. One command is captured per transaction.
// The selected operand is shifted STEP bits per BUSY cycle until the
// remaining amount reaches zero. The result, carry and a one-cycle done flag
// are then registered.
//
// Handshake: SHIFT_Enable is sampled only in IDLE, and a sampled high starts
// a transaction. SHIFT_Busy stays high from the cycle after capture through
// the DONE cycle. SHIFT_Flag is high for exactly one cycle, in DONE. While
// busy, all inputs are ignored.
module shift_unit_seq #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SHIFT_Src_sel,
  input  logic [2:0]       SHIFT_Op,
  input  logic [AMT_W-1:0] SHIFT_Amt,
  input  logic             SHIFT_Enable,
  output logic             SHIFT_Busy,
  output logic [WIDTH-1:0] SHIFT_Out,
  output logic             SHIFT_Flag,
  output logic             SHIFT_Carry,
  output logic             SHIFT_Zero,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [2:0] OP_SRL = 3'd0;
  localparam logic [2:0] OP_SLL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;

  localparam logic [AMT_W-1:0] STEP_K = AMT_W'(STEP);

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [2:0]         op_r;
  logic [AMT_W-1:0]   rem;
  logic               carry_work;

  logic [AMT_W-1:0]   k;
  logic [AMT_W-1:0]   km1;
  logic [AMT_W-1:0]   wmk;
  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] rot;
  logic [WIDTH-1:0]   nxt_work;
  logic               nxt_carry;

  assign SHIFT_Busy = (state != S_IDLE);
  assign SHIFT_Zero = (SHIFT_Out == '0);
  assign dbg_state  = state;

  // One step of the captured op by k = min(STEP, rem) bits, plus the last bit it pushes out.
  always_comb begin
    k         = (rem < STEP_K) ? rem : STEP_K;
    km1       = k - 1'b1;
    wmk       = AMT_W'(WIDTH - int'(k));
    dbl       = {work, work};
    rot       = '0;
    nxt_work  = work;
    nxt_carry = carry_work;
    case (op_r)
      OP_SRL: begin
        nxt_work  = work >> k;
        nxt_carry = work[km1];
      end
      OP_SLL: begin
        nxt_work  = work << k;
        nxt_carry = work[wmk];
      end
      OP_SRA: begin
        nxt_work  = $unsigned($signed(work) >>> k);
        nxt_carry = work[km1];
      end
      OP_ROR: begin
        rot       = dbl >> k;
        nxt_work  = rot[WIDTH-1:0];
        nxt_carry = work[km1];
      end
      OP_ROL: begin
        rot       = dbl << k;
        nxt_work  = rot[2*WIDTH-1:WIDTH];
        nxt_carry = work[wmk];
      end
      default: begin
        nxt_work  = work;
        nxt_carry = carry_work;
      end
    endcase
  end

  // Control FSM: capture in IDLE, step in BUSY, publish the result and pulse the flag into DONE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      work        <= '0;
      op_r        <= '0;
      rem         <= '0;
      carry_work  <= 1'b0;
      SHIFT_Out   <= '0;
      SHIFT_Carry <= 1'b0;
      SHIFT_Flag  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (SHIFT_Enable) begin
            work       <= SHIFT_Src_sel ? B : A;
            op_r       <= SHIFT_Op;
            // Reserved ops pass the operand through untouched.
            rem        <= (SHIFT_Op > OP_ROL) ? '0 : SHIFT_Amt;
            carry_work <= 1'b0;
            state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (rem != '0) begin
            work       <= nxt_work;
            carry_work <= nxt_carry;
            rem        <= rem - k;
          end else begin
            SHIFT_Out   <= work;
            SHIFT_Carry <= carry_work;
            SHIFT_Flag  <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          SHIFT_Flag <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          SHIFT_Flag <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq. Two instances run side by side on shared
// inputs: index 0 uses STEP=1 and index 1 uses STEP=4.
module tb_shift_unit_seq;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic [W-1:0] a_in   = '0;
  logic [W-1:0] b_in   = '0;
  logic         src    = 1'b0;
  logic [2:0]   op     = 3'd0;
  logic [3:0]   amt    = 4'd0;
  logic         en     = 1'b0;

  logic         busy_o  [2];
  logic [W-1:0] out_o   [2];
  logic         flag_o  [2];
  logic         carry_o [2];
  logic         zero_o  [2];
  logic [1:0]   dbg_o   [2];

  shift_unit_seq #(.WIDTH(W), .STEP(1)) dut0 (
    .CLK(CLK), .RST(RST), .A(a_in), .B(b_in), .SHIFT_Src_sel(src),
    .SHIFT_Op(op), .SHIFT_Amt(amt), .SHIFT_Enable(en),
    .SHIFT_Busy(busy_o[0]), .SHIFT_Out(out_o[0]), .SHIFT_Flag(flag_o[0]),
    .SHIFT_Carry(carry_o[0]), .SHIFT_Zero(zero_o[0]), .dbg_state(dbg_o[0])
  );

  shift_unit_seq #(.WIDTH(W), .STEP(4)) dut1 (
    .CLK(CLK), .RST(RST), .A(a_in), .B(b_in), .SHIFT_Src_sel(src),
    .SHIFT_Op(op), .SHIFT_Amt(amt), .SHIFT_Enable(en),
    .SHIFT_Busy(busy_o[1]), .SHIFT_Out(out_o[1]), .SHIFT_Flag(flag_o[1]),
    .SHIFT_Carry(carry_o[1]), .SHIFT_Zero(zero_o[1]), .dbg_state(dbg_o[1])
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic checking = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Whole-amount result from plain arithmetic: {carry, result}.
  function automatic logic [W:0] calc(input logic [2:0] o, input logic [W-1:0] x, input int n);
    logic [W-1:0] r;
    logic [W-1:0] t;
    logic c;
    r = x;
    c = 1'b0;
    if (o > 3'd4 || n == 0) return {1'b0, x};
    case (o)
      3'd0: begin r = x >> n; t = x >> (n - 1); c = t[0]; end
      3'd1: begin r = x << n; t = x >> (W - n); c = t[0]; end
      3'd2: begin r = W'($signed(x) >>> n); t = x >> (n - 1); c = t[0]; end
      3'd3: begin r = (x >> n) | (x << (W - n)); c = r[W-1]; end
      default: begin r = (x << n) | (x >> (W - n)); c = r[0]; end
    endcase
    return {c, r};
  endfunction

  function automatic int lat_of(input int i, input logic [2:0] o, input int n);
    int s;
    int ne;
    s  = (i == 0) ? 1 : 4;
    ne = (o > 3'd4) ? 0 : n;
    return (ne + s - 1) / s + 1;
  endfunction

  logic         m_idle [2] = '{1'b1, 1'b1};
  int           m_cnt  [2] = '{0, 0};
  int           m_lat  [2] = '{0, 0};
  logic [W:0]   m_pend [2] = '{'0, '0};
  logic [W-1:0] m_out  [2] = '{'0, '0};
  logic         m_c    [2] = '{1'b0, 1'b0};
  logic         m_flag [2] = '{1'b0, 1'b0};
  logic         m_busy [2] = '{1'b0, 1'b0};

  // Transaction schedule: result appears lat edges after capture, idle one edge later.
  always @(posedge CLK or negedge RST) begin
    for (int i = 0; i < 2; i++) begin
      if (!RST) begin
        m_idle[i] = 1'b1; m_cnt[i] = 0; m_out[i] = '0; m_c[i] = 1'b0;
        m_flag[i] = 1'b0; m_busy[i] = 1'b0;
      end else if (m_idle[i]) begin
        if (en) begin
          m_pend[i] = calc(op, src ? b_in : a_in, int'(amt));
          m_lat[i]  = lat_of(i, op, int'(amt));
          m_cnt[i]  = 0;
          m_idle[i] = 1'b0;
          m_busy[i] = 1'b1;
        end
      end else begin
        m_cnt[i]++;
        if (m_cnt[i] == m_lat[i]) begin
          m_out[i]  = m_pend[i][W-1:0];
          m_c[i]    = m_pend[i][W];
          m_flag[i] = 1'b1;
        end else if (m_cnt[i] == m_lat[i] + 1) begin
          m_flag[i] = 1'b0;
          m_idle[i] = 1'b1;
          m_busy[i] = 1'b0;
        end
      end
    end
  end

  // Scoreboard: every cycle, both instances against the model.
  always @(negedge CLK) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("cyc busy%0d", i),  32'(busy_o[i]),  32'(m_busy[i]));
        chk($sformatf("cyc flag%0d", i),  32'(flag_o[i]),  32'(m_flag[i]));
        chk($sformatf("cyc out%0d", i),   32'(out_o[i]),   32'(m_out[i]));
        chk($sformatf("cyc carry%0d", i), 32'(carry_o[i]), 32'(m_c[i]));
        chk($sformatf("cyc zero%0d", i),  32'(zero_o[i]),  32'(m_out[i] == '0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One transaction; records flag timing relative to the capture edge E0.
  task automatic run_op(input string nm, input logic s, input logic [2:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] n,
                        input logic [W-1:0] eo, input logic ec, input int l0, input int l1,
                        input int pulse_e);
    int e, emax, bc0;
    int f[2];
    int nf[2];
    logic [W-1:0] o_s[2];
    logic c_s[2];
    logic z_s[2];
    logic [W-1:0] mo_s;
    f = '{-1, -1}; nf = '{0, 0}; bc0 = 0; mo_s = '0;
    o_s = '{'0, '0}; c_s = '{1'b0, 1'b0}; z_s = '{1'b0, 1'b0};
    emax = ((l0 > l1) ? l0 : l1) + 4;
    @(negedge CLK);
    src = s; op = o; a_in = a; b_in = b; amt = n; en = 1'b1;
    @(posedge CLK);
    e = 0;
    while (e <= emax) begin
      @(negedge CLK);
      if (e == 0) begin
        en = 1'b0; a_in = ~a; b_in = ~b; amt = ~n; src = ~s;
      end
      if (pulse_e != 0 && e == pulse_e) begin
        a_in = 16'h0000; b_in = 16'h0000; op = 3'd1; amt = 4'd1; en = 1'b1;
      end
      if (pulse_e != 0 && e == pulse_e + 1) en = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (flag_o[i]) begin
          nf[i]++;
          if (f[i] < 0) begin
            f[i] = e; o_s[i] = out_o[i]; c_s[i] = carry_o[i]; z_s[i] = zero_o[i];
            if (i == 0) mo_s = m_out[0];
          end
        end
      end
      if (busy_o[0]) bc0++;
      @(posedge CLK);
      e++;
    end
    chk({nm, " lat0"}, 32'(f[0]), 32'(l0));
    chk({nm, " lat1"}, 32'(f[1]), 32'(l1));
    chk({nm, " nflag0"}, 32'(nf[0]), 32'd1);
    chk({nm, " nflag1"}, 32'(nf[1]), 32'd1);
    chk({nm, " busycyc0"}, 32'(bc0), 32'(l0 + 1));
    chk({nm, " model"}, 32'(mo_s), 32'(eo));
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s out%0d", nm, i),   32'(o_s[i]), 32'(eo));
      chk($sformatf("%s carry%0d", nm, i), 32'(c_s[i]), 32'(ec));
      chk($sformatf("%s zero%0d", nm, i),  32'(z_s[i]), 32'(eo == '0));
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s busy%0d", nm, i),  32'(busy_o[i]),  32'd0);
      chk($sformatf("%s flag%0d", nm, i),  32'(flag_o[i]),  32'd0);
      chk($sformatf("%s out%0d", nm, i),   32'(out_o[i]),   32'd0);
      chk($sformatf("%s carry%0d", nm, i), 32'(carry_o[i]), 32'd0);
      chk($sformatf("%s zero%0d", nm, i),  32'(zero_o[i]),  32'd1);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int nfl;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_reset_vals("reset");
    #2 RST = 1'b1;
    checking = 1'b1;
    repeat (2) @(posedge CLK);

    //     name     src   op     A         B         n      out       c     l0  l1  pulse
    run_op("srl",   1'b0, 3'd0, 16'hF0F1, 16'h0000, 4'd4,  16'h0F0F, 1'b0, 5,  2,  0);
    run_op("sra_b", 1'b1, 3'd2, 16'h1111, 16'h8001, 4'd3,  16'hF000, 1'b0, 4,  2,  0);
    run_op("rol",   1'b0, 3'd4, 16'h8001, 16'h0000, 4'd1,  16'h0003, 1'b1, 2,  2,  0);
    run_op("ror15", 1'b0, 3'd3, 16'h0001, 16'h0000, 4'd15, 16'h0002, 1'b0, 16, 5,  0);
    run_op("sll0",  1'b0, 3'd1, 16'h0000, 16'h0000, 4'd0,  16'h0000, 1'b0, 1,  1,  0);
    run_op("sll6",  1'b0, 3'd1, 16'h8421, 16'h0000, 4'd6,  16'h0840, 1'b1, 7,  3,  0);
    run_op("sra5",  1'b0, 3'd2, 16'hF0F1, 16'h0000, 4'd5,  16'hFF87, 1'b1, 6,  3,  0);
    run_op("ignore",1'b0, 3'd0, 16'hFFFF, 16'h0000, 4'd12, 16'h000F, 1'b1, 13, 4,  2);
    run_op("resv",  1'b0, 3'd6, 16'h1234, 16'h0000, 4'd7,  16'h1234, 1'b0, 1,  1,  0);

    // Reset in the middle of an SRL by 12: outputs clear at once, no flag afterwards.
    @(negedge CLK);
    src = 1'b0; op = 3'd0; a_in = 16'hFFFF; amt = 4'd12; en = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    en = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    #1 chk_reset_vals("midreset");
    @(negedge CLK);
    #2 RST = 1'b1;
    nfl = 0;
    repeat (20) begin
      @(negedge CLK);
      if (flag_o[0] || flag_o[1]) nfl++;
    end
    chk("postreset noflag", 32'(nfl), 32'd0);
    run_op("after", 1'b0, 3'd3, 16'h0001, 16'h0000, 4'd1, 16'h8000, 1'b1, 2, 2, 0);

    checking = 1'b0;
    @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_unit_seq.md
# shift_unit_seq

Parametrised multi-cycle shift/rotate engine, the next-generation shift unit of the ALU datapath. It accepts one command per transaction through a start/busy/done handshake and selects operand A or B. It supports logical, arithmetic and rotate operations by a variable amount, shifting STEP bits per cycle. It returns a registered result with a one-cycle done flag, the last bit shifted out, and a zero flag.

## Interface
- WIDTH, 16: operand/result width; power of 2, ≥4
- STEP, 1: bits shifted per BUSY cycle; power of 2, 1..WIDTH/2
- AMT_W (localparam) = $clog2(WIDTH)
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- A  in  WIDTH  operand 0
- B  in  WIDTH  operand 1
- SHIFT_Src_sel  in  1  0 selects A, 1 selects B
- SHIFT_Op  in  3  000 SRL, 001 SLL, 010 SRA, 011 ROR, 100 ROL, 101–111 reserved
- SHIFT_Amt  in  AMT_W  shift amount, 0..WIDTH-1
- SHIFT_Enable  in  1  start request; sampled only in IDLE
- SHIFT_Busy  out  1  high in BUSY and DONE
- SHIFT_Out  out  WIDTH  result register
- SHIFT_Flag  out  1  done pulse, one cycle
- SHIFT_Carry  out  1  last bit shifted/rotated out
- SHIFT_Zero  out  1  SHIFT_Out == 0

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - On a clock edge with SHIFT_Enable=1, latch the selected operand into the work register, latch op into the op register, and latch rem=SHIFT_Amt.
  - Go to BUSY.
- BUSY:
  - rem≠0: k=min(STEP,rem); apply the op by k bits to the work register; rem-=k.
  - rem==0: load SHIFT_Out and SHIFT_Carry, set SHIFT_Flag=1, go to DONE.
- DONE: clear SHIFT_Flag, go to IDLE.
- SHIFT_Enable is ignored in BUSY and DONE. Changes to A, B, SHIFT_Op, SHIFT_Amt or SHIFT_Src_sel after capture have no effect.
- SRL and SLL fill with 0. SRA fills with the captured operand MSB. ROR and ROL are circular.
- Carry, with amount n and captured operand X:
  - n=0: 0.
  - SRL/SRA: X[n-1].
  - SLL: X[WIDTH-n].
  - ROR: SHIFT_Out[WIDTH-1].
  - ROL: SHIFT_Out[0].
- Reserved ops: rem is forced to 0 at capture. Result = X unchanged, Carry=0.
- SHIFT_Out, SHIFT_Carry and SHIFT_Zero hold their values until the next DONE entry or reset. SHIFT_Zero is derived from the SHIFT_Out register.

## Timing
- Reset (asynchronous, any state): state=IDLE, SHIFT_Out=0, SHIFT_Flag=0, SHIFT_Carry=0, SHIFT_Zero=1, SHIFT_Busy=0. Any in-flight op is discarded with no flag.
- Capture edge E0. SHIFT_Flag is high for exactly the cycle after edge E(ceil(n/STEP)+1); latency = ceil(n/STEP)+1 cycles.
- SHIFT_Flag falls on the next edge. IDLE is re-entered on that same edge.
- Minimum spacing between captures is ceil(n/STEP)+3 edges. An Enable held high re-captures on the first IDLE edge.
- SHIFT_Busy is decoded from the state register, so it is glitch-free. It rises the cycle after E0.

## Test plan
- WIDTH=16, STEP=1, SRL, A=0xF0F1, n=4, Src=0:
  - Flag is high after edge 5; Out=0x0F0F, Carry=0, Zero=0.
  - Busy is high for 6 cycles.
- SRA, B=0x8001, n=3, Src=1 -> Out=0xF000, Carry=0. ROL, A=0x8001, n=1 -> Out=0x0003, Carry=1.
- STEP=4, ROR, A=0x0001, n=15 -> Flag after edge 5 (ceil(15/4)+1), Out=0x0002, Carry=0.
- SLL, A=0x0000, n=0 -> Flag after edge 1, Out=0x0000, Carry=0, Zero=1. Reserved op 110, A=0x1234 -> Out=0x1234 after edge 1.
- Pulse SHIFT_Enable with new operands during BUSY -> ignored; the first result is unchanged and no second Flag appears.
- Assert RST low mid-BUSY (SRL, n=12) -> outputs at reset values immediately. After release, Flag never fires for the aborted op, and a new op completes normally.
